// File: rtl/pair_serializer_pkg.sv
// pair_serializer_pkg: shared lane state and default sizing for the pair serializer
package pair_serializer_pkg;
   typedef enum logic {SEND1 = 1'b0, SEND2 = 1'b1} lane_t;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int DEPTH_DEF = 4;
endpackage

// File: rtl/pair_fifo.sv
// pair_fifo: DEPTH-entry FIFO of byte pairs with occupancy count
module pair_fifo
   import pair_serializer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    pop,
   input  logic [2*DATA_WIDTH-1:0] wr_data,
   output logic [2*DATA_WIDTH-1:0] head,
   output logic                    full,
   output logic                    empty,
   output logic [CNT_W-1:0]        count
);
   localparam int PTR_W = $clog2(DEPTH);
   logic [2*DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wr_data;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   assign head  = mem[rd_ptr];
   assign full  = count == CNT_W'(DEPTH);
   assign empty = count == '0;
endmodule

// File: rtl/pair_serializer.sv
// pair_serializer: buffers byte pairs and emits them lane-1 then lane-2 on one stream
module pair_serializer
   import pair_serializer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] data_in1,
   input  logic [DATA_WIDTH-1:0] data_in2,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  out_lane,
   output logic [CNT_W-1:0]      count
);
   lane_t state;
   logic [2*DATA_WIDTH-1:0] head;
   logic full, empty, push, pop;
   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready & (state == SEND2);
   pair_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(push),
      .pop(pop),
      .wr_data({data_in1, data_in2}),
      .head(head),
      .full(full),
      .empty(empty),
      .count(count)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= SEND1;
      else if (out_valid & out_ready) state <= (state == SEND1) ? SEND2 : SEND1;
   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign out_lane  = out_valid & (state == SEND2);
   assign data_out  = !out_valid ? '0 : (state == SEND2) ? head[DATA_WIDTH-1:0] : head[2*DATA_WIDTH-1:DATA_WIDTH];
endmodule

// File: tb/tb_pair_serializer.sv
// tb_pair_serializer: scoreboard bench with directed scenarios and random traffic
module tb_pair_serializer;
   localparam int DEPTH = 4;
   typedef struct packed {logic [7:0] d; logic l;} ent_t;
   logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
   logic [7:0] data_in1 = 0, data_in2 = 0;
   logic in_ready, out_valid, out_lane;
   logic [7:0] data_out;
   logic [2:0] count;
   ent_t exp_q[$];
   int n_cmp = 0, n_bad = 0;

   pair_serializer dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .data_in1(data_in1), .data_in2(data_in2), .out_valid(out_valid),
      .out_ready(out_ready), .data_out(data_out), .out_lane(out_lane), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // scoreboard: queue holds pending bytes in emission order; count is pairs = ceil(bytes/2)
   always @(negedge clk) if (!reset) begin
      int p;
      p = exp_q.size();
      chk("count", count, (p + 1) / 2);
      chk("in_ready", in_ready, ((p + 1) / 2) != DEPTH);
      chk("out_valid", out_valid, p != 0);
      if (p == 0) begin
         chk("idle_data", data_out, 0);
         chk("idle_lane", out_lane, 0);
      end else begin
         chk("data_out", data_out, exp_q[0].d);
         chk("out_lane", out_lane, exp_q[0].l);
         if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
         exp_q.push_back('{d: data_in1, l: 1'b0});
         exp_q.push_back('{d: data_in2, l: 1'b1});
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
      logic h;
      bit done = 0;
      in_valid = 1;
      data_in1 = a;
      data_in2 = b;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk) h = in_ready;
         cyc();
         done = h;
      end
      if (!done) chk("push_timeout", 0, 1);
      in_valid = 0;
   endtask

   task automatic drain();
      bit done = 0;
      out_ready = 1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (exp_q.size() == 0) done = 1;
         else cyc();
      end
      if (!done) chk("drain_timeout", 0, 1);
      cyc(2);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_data_out"}, data_out, 0);
      chk({tag, "_out_lane"}, out_lane, 0);
      chk({tag, "_count"}, count, 0);
   endtask

   logic [7:0] seq_a [10] = '{8'hAB, 8'h08, 8'hF2, 8'hCC, 8'h67, 8'h49, 8'hB1, 8'h00, 8'h12, 8'h3D};
   logic [7:0] seq_b [10] = '{8'hE2, 8'hBB, 8'h90, 8'h54, 8'hC3, 8'h4E, 8'hFF, 8'hFF, 8'h34, 8'h00};

   initial begin
      cyc(2);
      chk_reset_outs("rst");
      reset = 0;
      cyc();
      out_ready = 1;
      push_pair(8'hAB, 8'hE2);
      chk("lat_valid", out_valid, 1);
      chk("lat_first", data_out, 8'hAB);
      drain();
      out_ready = 0;
      for (int i = 0; i < 4; i++) push_pair(seq_a[i], seq_b[i]);
      in_valid = 1;
      data_in1 = 8'h49;
      data_in2 = 8'h4E;
      cyc(3);
      chk("full_count", count, 4);
      chk("full_ready", in_ready, 0);
      out_ready = 1;
      push_pair(8'h49, 8'h4E);
      drain();
      out_ready = 0;
      push_pair(8'hB1, 8'hFF);
      out_ready = 1;
      cyc();
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("bp_data", data_out, 8'hFF);
         chk("bp_lane", out_lane, 1);
         chk("bp_count", count, 1);
      end
      out_ready = 1;
      cyc();
      chk("bp_pop", count, 0);
      for (int i = 0; i < 10; i++) push_pair(seq_a[i], seq_b[i]);
      drain();
      out_ready = 0;
      for (int i = 0; i < 3; i++) push_pair(seq_a[i+2], seq_b[i+2]);
      out_ready = 1;
      cyc();
      out_ready = 0;
      chk("mid_lane", out_lane, 1);
      chk("mid_count", count, 3);
      reset = 1;
      #1;
      chk_reset_outs("async");
      exp_q.delete();
      cyc();
      reset = 0;
      out_ready = 1;
      push_pair(8'h3D, 8'h00);
      chk("post_rst_data", data_out, 8'h3D);
      chk("post_rst_lane", out_lane, 0);
      drain();
      out_ready = 0;
      push_pair(8'h11, 8'h22);
      push_pair(8'h33, 8'h44);
      out_ready = 1;
      cyc();
      in_valid = 1;
      data_in1 = 8'h55;
      data_in2 = 8'h66;
      cyc();
      in_valid = 0;
      chk("pp_count", count, 2);
      drain();
      for (int i = 0; i < 600; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         data_in1 = 8'($urandom);
         data_in2 = 8'($urandom);
         out_ready = 1'($urandom_range(0, 3) != 0);
         cyc();
      end
      in_valid = 0;
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
